uart_tx_arb: RTL and testbench



---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_rr_pick.sv | 33 +++
 rtl/uart_tx_arb.sv | 146 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit arbiter.
package uart_pkg;

    localparam int DEFAULT_NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotating-priority pick: first set request at or above ptr_i, wrapping.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic                       valid_o
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        gnt_o   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = PW'((int'(ptr_i) + i) % NUM_REQ);
            if (!w_found && req_i[w_idx]) begin
                gnt_o[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

    assign valid_o = w_found;

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources.
// Optional WAIT_DONE watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = DEFAULT_NUM_REQ,
    parameter int CLK_FREQ       = 100_000_000,
    parameter int UART_BPS       = 115200,
    parameter int TIMEOUT_CYCLES = 12 * (CLK_FREQ / UART_BPS)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*8-1:0]       data_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic                       tx_start_o,
    output logic [7:0]                 tx_data_o,
    input  logic                       tx_done_i,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] owner_o,
    output logic                       timeout_o,
    output logic [1:0]                 dbg_state_o
);

    localparam int PW = $clog2(NUM_REQ);

    // Handshake: a byte is accepted when gnt_o[k] pulses (same cycle as
    // tx_start_o); the transfer ends on a tx_done_i pulse seen in WAIT_DONE.
    state_t               r_state;
    logic [PW-1:0]        r_rr_ptr;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_tx_start;
    logic [7:0]           r_tx_data;
    logic                 r_busy;
    logic [PW-1:0]        r_owner;
    logic                 r_timeout;

    logic [NUM_REQ-1:0]   w_pick_gnt;
    logic                 w_pick_valid;
    logic [PW-1:0]        w_pick_idx;
    logic [7:0]           w_pick_data;
    logic [PW-1:0]        w_ptr_next;
    logic                 w_wd_expire;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i   (req_i),
        .ptr_i   (r_rr_ptr),
        .gnt_o   (w_pick_gnt),
        .valid_o (w_pick_valid)
    );

    always_comb begin
        w_pick_idx  = '0;
        w_pick_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_pick_gnt[k]) begin
                w_pick_idx  = PW'(k);
                w_pick_data = data_i[k*8 +: 8];
            end
        end
    end

    assign w_ptr_next = (r_owner == PW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_wd_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wd_cnt <= '0;
        end else if (r_state == ST_LAUNCH) begin
            r_wd_cnt <= '0;
        end else if (r_state == ST_WAIT_DONE) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    // Fire on the increment that takes the count to TIMEOUT_CYCLES-1, so the
    // registered pulse lands TIMEOUT_CYCLES cycles after LAUNCH.
    assign w_wd_expire = (r_state == ST_WAIT_DONE) && (r_wd_cnt == CW'(TIMEOUT_CYCLES - 2));
`else
    assign w_wd_expire = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_gnt      <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_busy     <= 1'b0;
            r_owner    <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_gnt      <= '0;
            r_tx_start <= 1'b0;
            r_timeout  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_valid) begin
                        r_owner    <= w_pick_idx;
                        r_tx_data  <= w_pick_data;
                        r_gnt      <= w_pick_gnt;
                        r_tx_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    r_rr_ptr <= w_ptr_next;
                    r_state  <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (tx_done_i) begin
                        r_state <= ST_GAP;
                    end else if (w_wd_expire) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt_o       = r_gnt;
    assign tx_start_o  = r_tx_start;
    assign tx_data_o   = r_tx_data;
    assign busy_o      = r_busy;
    assign owner_o     = r_owner;
    assign timeout_o   = r_timeout;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: directed scenarios plus randomized traffic checked by a
// round-robin reference model and a grant scoreboard.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int TO = 50;
    localparam int W  = 10;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*8-1:0]   data;
    logic [N-1:0]     gnt;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_done;
    logic             busy;
    logic [1:0]       owner;
    logic             timeout;
    logic [1:0]       dbg_state;

    int               checks = 0;
    int               errors = 0;
    logic [W-1:0]     exp_q[$];
    logic [W-1:0]     mon_e;
    int               m_ptr = 0;
    int               last_w = 0;
    int               to_seen = 0;

    uart_tx_arb #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .data_i      (data),
        .gnt_o       (gnt),
        .tx_start_o  (tx_start),
        .tx_data_o   (tx_data),
        .tx_done_i   (tx_done),
        .busy_o      (busy),
        .owner_o     (owner),
        .timeout_o   (timeout),
        .dbg_state_o (dbg_state)
    );

    // clock / global time limit
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation still running, expected completion");
        $fatal(1, "time limit");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: first pending requester at or after the model pointer, wrapping.
    function automatic int model_pick(input logic [N-1:0] r);
        for (int i = 0; i < N; i++) begin
            int k = (m_ptr + i) % N;
            if (r[k]) return k;
        end
        return -1;
    endfunction

    task automatic expect_next();
        int w;
        w = model_pick(req);
        if (w < 0) begin
            checks++;
            errors++;
            $display("FAIL model_pick: got no requester expected at least one pending");
        end else begin
            exp_q.push_back({2'(w), data[w*8 +: 8]});
            m_ptr  = (w + 1) % N;
            last_w = w;
        end
    endtask

    task automatic wait_start();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_start) begin
                ok = 1'b1;
                break;
            end
        end
        check("start_seen", 32'(ok), 32'd1);
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_gnt"},      32'(gnt),      32'd0);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_tx_data"},  32'(tx_data),  32'h00);
        check({tag, "_owner"},    32'(owner),    32'd0);
        check({tag, "_timeout"},  32'(timeout),  32'd0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (timeout) to_seen++;
            if (tx_start) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_grant: got owner %0d data %0h expected no grant", owner, tx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("grant_owner",  32'(owner),   32'(mon_e[9:8]));
                    check("grant_data",   32'(tx_data), 32'(mon_e[7:0]));
                    check("grant_onehot", 32'(gnt),     32'd1 << mon_e[9:8]);
                end
            end else if (gnt != '0) begin
                check("gnt_without_start", 32'(gnt), 32'd0);
            end
        end
    end

    int exp_order[5] = '{0, 1, 2, 3, 0};
    int to_base;
    int to_at;

    initial begin
        rst     = 1'b1;
        req     = '0;
        data    = '0;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        // single requester, latency and hold behaviour
        req       = 4'b0001;
        data[7:0] = 8'hA5;
        expect_next();
        @(negedge clk);
        check("lat_start", 32'(tx_start), 32'd1);
        check("lat_gnt",   32'(gnt),      32'h1);
        check("lat_data",  32'(tx_data),  32'hA5);
        req = '0;
        repeat (19) @(negedge clk);
        check("wait_busy", 32'(busy), 32'd1);
        pulse_done();
        check("gap_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("idle_busy",  32'(busy),    32'd0);
        check("hold_data",  32'(tx_data), 32'hA5);
        check("hold_owner", 32'(owner),   32'd0);

        // done pulse while idle must be ignored
        pulse_done();
        repeat (3) begin
            @(negedge clk);
            check("idle_done_busy", 32'(busy), 32'd0);
        end

        // pointer at 2 with requesters 0 and 1 pending
        req        = 4'b0010;
        data[15:8] = 8'($urandom);
        expect_next();
        wait_start();
        req       = 4'b0011;
        data[7:0] = 8'($urandom);
        expect_next();
        repeat (3) @(negedge clk);
        pulse_done();
        wait_start();
        check("rr2_first", 32'(owner), 32'd0);
        req[0] = 1'b0;
        expect_next();
        repeat (4) @(negedge clk);
        pulse_done();
        wait_start();
        check("rr2_second", 32'(owner), 32'd1);
        req = '0;
        repeat (2) @(negedge clk);
        pulse_done();
        repeat (2) @(negedge clk);

        // reset during WAIT_DONE, then full rotation from requester 0
        req         = 4'b0100;
        data[23:16] = 8'($urandom);
        expect_next();
        wait_start();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("abort");
        check("abort_q_empty", 32'(exp_q.size()), 32'd0);
        m_ptr = 0;
        req   = 4'b1111;
        for (int k = 0; k < N; k++) data[k*8 +: 8] = 8'($urandom);
        for (int t = 0; t < 5; t++) begin
            expect_next();
            wait_start();
            check("rot_owner", 32'(owner), 32'(exp_order[t]));
            data[last_w*8 +: 8] = 8'($urandom);
            if (t == 4) req = '0;
            repeat (9) @(negedge clk);
            pulse_done();
        end
        repeat (3) @(negedge clk);

        // watchdog behaviour
        req = 4'b0011;
        data[15:0] = 16'($urandom);
        expect_next();
        wait_start();
        req[last_w] = 1'b0;
        expect_next();
        to_base = to_seen;
`ifdef UART_ARB_TIMEOUT_EN
        to_at = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (timeout) begin
                to_at = i;
                break;
            end
        end
        check("timeout_cycle", 32'(to_at), 32'(TO));
        wait_start();
`else
        repeat (TO + 10) @(negedge clk);
        check("no_timeout", 32'(to_seen - to_base), 32'd0);
        check("still_busy", 32'(busy), 32'd1);
        pulse_done();
        wait_start();
`endif
        req = '0;
        repeat (2) @(negedge clk);
        pulse_done();
        repeat (3) @(negedge clk);

        // randomized traffic against the reference model
        req = '0;
        for (int k = 0; k < N; k++) begin
            if ($urandom_range(0, 1) == 1) begin
                data[k*8 +: 8] = 8'($urandom);
                req[k] = 1'b1;
            end
        end
        if (req == '0) begin
            data[7:0] = 8'($urandom);
            req[0]    = 1'b1;
        end
        expect_next();
        for (int it = 0; it < 60; it++) begin
            wait_start();
            if ($urandom_range(0, 1) == 1) req[last_w] = 1'b0;
            else data[last_w*8 +: 8] = 8'($urandom);
            for (int k = 0; k < N; k++) begin
                if (!req[k] && $urandom_range(0, 2) == 0) begin
                    data[k*8 +: 8] = 8'($urandom);
                    req[k] = 1'b1;
                end
            end
            if (req == '0) begin
                int k;
                k = $urandom_range(0, N - 1);
                data[k*8 +: 8] = 8'($urandom);
                req[k] = 1'b1;
            end
            repeat (1 + $urandom_range(0, 12)) @(negedge clk);
            if (it == 59) req = '0;
            else expect_next();
            pulse_done();
        end
        repeat (4) @(negedge clk);
        check("final_idle", 32'(busy), 32'd0);
        check("q_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
